// File: rtl/bitscan_iter.sv
// bitscan_iter: multi-cycle CTZ / CLZ / POPCNT unit scanning STEP bits per clock,
// with valid/ready streams on both sides.
// Optional feature macro: BITSCAN_POPCNT_EN (POPCNT mode and its per-chunk adder).
// Without it, in_mode=2 behaves like the reserved mode 3.
module bitscan_iter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_zero
);

  localparam int NCH = WIDTH / STEP;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  typedef enum logic [1:0] {OP_CTZ, OP_CLZ, OP_POP, OP_NONE} op_t;

  state_t           state_q, state_d;
  op_t              op_q, op_in;
  logic [WIDTH-1:0] data_q, in_rev;
  logic [KW-1:0]    k_q, k_d;
  logic [CW-1:0]    acc_q, acc_d;
  logic             zero_q;
  logic             accept;

  logic [STEP-1:0]  chunk;
  logic             chunk_nz;
  logic [CW-1:0]    pos;
  logic [CW-1:0]    base;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign out_count = acc_q;
  assign out_zero  = zero_q;

  // Bit-reversed operand: CLZ is scanned as CTZ of the mirrored word, so
  // chunk k always sits at bits [k*STEP +: STEP] of the captured register.
  always_comb begin
    in_rev = '0;
    for (int unsigned i = 0; i < WIDTH; i++)
      in_rev[i] = in_data[WIDTH-1-i];
  end

  // Decode the requested mode into the internal operation.
  always_comb begin
    case (in_mode)
      2'd0:    op_in = OP_CTZ;
      2'd1:    op_in = OP_CLZ;
`ifdef BITSCAN_POPCNT_EN
      2'd2:    op_in = OP_POP;
`endif
      default: op_in = OP_NONE;
    endcase
  end

  // Current chunk, its first set bit (from the scan end) and its base offset.
  always_comb begin
    chunk    = STEP'(data_q >> (STEP * k_q));
    chunk_nz = |chunk;
    pos      = '0;
    for (int unsigned i = STEP; i > 0; i--)
      if (chunk[i-1]) pos = CW'(i - 1);
    base = CW'(k_q) * CW'(STEP);
  end

`ifdef BITSCAN_POPCNT_EN
  logic [CW-1:0] chunk_pop;

  // Per-chunk population count feeding the POPCNT accumulator.
  always_comb begin
    chunk_pop = '0;
    for (int unsigned i = 0; i < STEP; i++)
      chunk_pop = chunk_pop + CW'(chunk[i]);
  end
`endif

  // Next-state and datapath update decisions.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = SCAN;
      end
      SCAN: begin
        case (op_q)
          OP_CTZ, OP_CLZ: begin
            if (chunk_nz) begin
              acc_d   = base + pos;
              state_d = DONE;
            end else if (k_q == KLAST) begin
              acc_d   = CW'(WIDTH);
              state_d = DONE;
            end else begin
              k_d = k_q + 1'b1;
            end
          end
`ifdef BITSCAN_POPCNT_EN
          OP_POP: begin
            acc_d = acc_q + chunk_pop;
            if (k_q == KLAST) state_d = DONE;
            else              k_d     = k_q + 1'b1;
          end
`endif
          default: begin
            acc_d   = '0;
            state_d = DONE;
          end
        endcase
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand capture, chunk index and accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      op_q   <= OP_NONE;
      k_q    <= '0;
      acc_q  <= '0;
      zero_q <= 1'b0;
    end else if (accept) begin
      data_q <= (in_mode == 2'd1) ? in_rev : in_data;
      op_q   <= op_in;
      k_q    <= '0;
      acc_q  <= '0;
      zero_q <= (in_data == '0);
    end else begin
      k_q   <= k_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: tb/tb_bitscan_iter.sv
// Scoreboard bench for bitscan_iter (WIDTH=32, STEP=4). Expected results come
// from a bit-serial reference model; define BITSCAN_POPCNT_EN for both DUT and
// bench to exercise the POPCNT build.
module tb_bitscan_iter;

  localparam int WIDTH = 32;
  localparam int STEP  = 4;
  localparam int NCH   = WIDTH / STEP;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [1:0]       in_mode = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [CW-1:0]    out_count;
  logic             out_zero;

  typedef struct {
    int unsigned cnt;
    int unsigned zero;
    int unsigned n;
    int unsigned e0;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          ov_prev = 1'b0;
  bit          hs_prev = 1'b0;

  bitscan_iter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count), .out_zero(out_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: bit-serial scan; n = chunks the unit must examine.
  task automatic model(input logic [1:0] mode, input logic [WIDTH-1:0] d,
                       output int unsigned cnt, output int unsigned n);
    cnt = 0;
    n   = 1;
    case (mode)
      2'd0: begin
        cnt = WIDTH;
        for (int i = WIDTH - 1; i >= 0; i--) if (d[i]) cnt = i;
        n = (cnt == WIDTH) ? NCH : cnt / STEP + 1;
      end
      2'd1: begin
        cnt = WIDTH;
        for (int i = 0; i < WIDTH; i++) if (d[i]) cnt = WIDTH - 1 - i;
        n = (cnt == WIDTH) ? NCH : cnt / STEP + 1;
      end
      2'd2: begin
`ifdef BITSCAN_POPCNT_EN
        for (int i = 0; i < WIDTH; i++) cnt += d[i];
        n = NCH;
`endif
      end
      default: ;
    endcase
  endtask

  task automatic send(input logic [1:0] mode, input logic [WIDTH-1:0] d);
    exp_t e;
    int unsigned waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = d;
    model(mode, d, e.cnt, e.n);
    e.zero = (d == '0);
    @(posedge clk);
    #1;
    e.e0 = cyc;
    sb.push_back(e);
    in_valid = 1'b0;
    in_mode  = 2'($urandom);
    in_data  = $urandom;
  endtask

  // Monitor: latency at the rising edge of out_valid, value/stability checks
  // while valid, and in_ready after each handshake.
  always @(negedge clk) begin
    if (rst) begin
      ov_prev = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) check("post_hs_in_ready", in_ready, 1);
      hs_prev = 1'b0;
      if (out_valid && !ov_prev) begin
        if (sb.size() == 0) check("spurious_out_valid", out_valid, 0);
        else                check("latency", cyc - sb[0].e0, sb[0].n);
      end
      if (out_valid && sb.size() > 0) begin
        check("out_count", out_count, sb[0].cnt);
        check("out_zero", out_zero, sb[0].zero);
        if (!out_ready) check("stall_in_ready", in_ready, 0);
        else begin
          void'(sb.pop_front());
          hs_prev = 1'b1;
        end
      end
      ov_prev = out_valid;
    end
  end

  initial begin
    int unsigned waited;
    logic [WIDTH-1:0] r;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_zero", out_zero, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("release_in_ready", in_ready, 1);

    send(2'd0, 32'h0000_0100);
    send(2'd1, 32'h0001_0000);
    send(2'd1, 32'h8000_0000);
    send(2'd0, 32'h0000_0000);
    send(2'd1, 32'h0000_0000);
    send(2'd0, 32'h8000_0000);
    send(2'd1, 32'h0000_0001);
    send(2'd2, 32'hF0F0_0001);
    send(2'd2, 32'h0000_0000);
    send(2'd3, 32'h0000_0005);
    send(2'd3, 32'h0000_0000);
    for (int i = 0; i < 24; i++) begin
      r = $urandom;
      if (i % 3 == 0) r = r & (r << 7) & (r << 13);
      send(2'($urandom_range(0, 3)), r);
    end

    // Backpressure: result held for 5 cycles while a competing operand is offered.
    waited = 0;
    while (sb.size() != 0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    out_ready = 1'b0;
    send(2'd0, 32'h0000_0001);
    waited = 0;
    while (!out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("stall_out_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_mode  = 2'd0;
      in_data  = 32'h0000_8000;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_not_captured", out_valid, 0);

    // Reset while scanning: the in-flight operand must vanish.
    send(2'd2, 32'hFFFF_FFFF);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_out_count", out_count, 0);
    check("post_rst_out_zero", out_zero, 0);
    send(2'd0, 32'h0000_0004);

    waited = 0;
    while ((sb.size() != 0 || out_valid) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitscan_iter.md
# bitscan_iter

Parametrised, multi-cycle bit-scan unit: counts trailing zeros (CTZ), leading zeros (CLZ), or set bits (POPCNT) of a WIDTH-bit word. It examines STEP bits per clock and stops early once the answer is known. It generalises the team's fixed 32-bit combinational bit-manipulation kernels into a handshaked, sequential datapath element. Inputs and results move through valid/ready streams.

## Interface
- WIDTH, 32: operand width; must be a multiple of STEP and at least 2.
- STEP, 4: bits examined per SCAN cycle; NCH = WIDTH/STEP chunks.
- CW, derived = $clog2(WIDTH+1): result width.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand offered.
- in_ready  out  1  high only in IDLE with rst low.
- in_data  in  WIDTH  operand.
- in_mode  in  2  0=CTZ, 1=CLZ, 2=POPCNT, 3=reserved.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts result.
- out_count  out  CW  result.
- out_zero  out  1  accepted operand was all zeros.

## Operation
- FSM states: IDLE, SCAN, DONE. Reset enters IDLE.
- IDLE: in_valid & in_ready captures in_data, in_mode, clears the accumulator and chunk index k, and moves to SCAN.
- SCAN: each cycle examines chunk k.
  - CTZ: chunk k is bits [k*STEP+STEP-1 : k*STEP].
  - CLZ: chunk k is bits [WIDTH-1-k*STEP : WIDTH-STEP-k*STEP].
- CTZ/CLZ: if the chunk is non-zero, result = k*STEP + position of its first set bit, counted from the scan end. Go to DONE.
- CTZ/CLZ, last chunk (k = NCH-1) all zero: result = WIDTH. Go to DONE.
- POPCNT: accumulator += popcount(chunk). Go to DONE after chunk NCH-1. No early exit.
- Mode 3: go to DONE after one SCAN cycle with out_count=0.
- out_zero = (captured operand == 0), valid in every mode.
- DONE: out_valid=1. out_count and out_zero are held stable until out_valid & out_ready, then return to IDLE.
- No bypass: a new operand can be accepted only in the cycle after the result handshake.
- Arithmetic: the accumulator is CW bits wide, unsigned, and cannot overflow (maximum WIDTH). The chunk index is $clog2(NCH) bits wide, minimum 1.
- in_mode and in_data are ignored outside the IDLE acceptance cycle.

## Timing
- Reset values: in_ready=0 while rst is high and 1 from the first cycle after release. out_valid=0, out_count=0, out_zero=0.
- Latency: let the accept edge be E0 and let N be the number of chunks examined. out_valid rises after edge E0+N.
  - CTZ/CLZ: N = 1..NCH.
  - POPCNT: N = NCH.
  - Mode 3: N = 1.
- Throughput: one result per N+2 cycles when out_ready is held high.
- out_ready held low: stay in DONE indefinitely with outputs frozen. in_ready stays 0.
- rst asserted in any state: next edge forces IDLE with all outputs at reset values. The in-flight operand is discarded and never produces out_valid.
- rst has priority over simultaneous in_valid/out_ready.

## Configuration
- BITSCAN_POPCNT_EN defined: POPCNT mode is present as specified, including the per-chunk popcount adder.
- BITSCAN_POPCNT_EN undefined: the adder is removed. in_mode=2 behaves exactly like mode 3: one SCAN cycle, out_count=0, out_zero still valid.
- CTZ/CLZ behaviour and all timing are identical in both builds.

## Test plan
All scenarios use WIDTH=32, STEP=4.
- CTZ, in_data=0x0000_0100: out_count=8, out_zero=0, out_valid after edge E0+3.
- CLZ, in_data=0x0001_0000: out_count=15, out_valid after E0+4.
- CLZ, in_data=0x8000_0000: out_count=0, out_valid after E0+1.
- CTZ, in_data=0x0000_0000: out_count=32, out_zero=1, out_valid after E0+8.
- POPCNT, in_data=0xF0F0_0001 with macro defined: out_count=9, out_valid after E0+8.
- Same POPCNT stimulus with macro undefined: out_count=0, out_valid after E0+1.
- Backpressure: CTZ of 0x1, out_ready low for 5 cycles:
  - out_valid=1 and out_count=0 stable throughout; in_ready=0.
  - after the handshake, in_ready=1 on the next cycle.
  - an operand offered during the stall is not captured.
- Reset mid-SCAN: POPCNT of 0xFFFF_FFFF with rst pulsed at E0+3:
  - out_valid never rises for that operand.
  - in_ready=1 on the cycle after rst deasserts.
  - a following CTZ of 0x4 returns 2.
